mips_cpu_mem_sequencer: RTL and testbench

- Multi-cycle controller for the Harvard datapath.
- Generates stall, storeloop and data-bus strobes from the current opcode, the memory wait-request handshakes and the datapath's active flag.
- Sequences SB/SH as a read-merge-write loop, holds the PC during memory waits, and detects halt and bus-timeout conditions.
- Sits beside the main decoder; its stall and storeloop outputs drive the datapath directly.

---
 rtl/mips_cpu_seq_pkg.sv | 41 ++++
 rtl/mips_cpu_wait_timer.sv | 34 +++
 rtl/mips_cpu_mem_sequencer.sv | 121 ++++++++++++
 tb/tb_mips_cpu_mem_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_seq_pkg.sv
// Shared types for the multi-cycle memory sequencer: FSM states, memory opcodes
// and the opcode classifier used to pick the bus sequence for an instruction.
package mips_cpu_seq_pkg;

    typedef enum logic [2:0] {
        RUN,
        RMW_CAPTURE,
        RMW_WRITE,
        HALTED,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONMEM,
        CLS_LOAD,
        CLS_SW,
        CLS_PSTORE
    } op_class_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Partial stores (SB/SH) need a read-merge-write; full-word SW does not.
    function automatic op_class_t op_class(input logic [5:0] opcode);
        case (opcode)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: op_class = CLS_LOAD;
            OP_SW:                                              op_class = CLS_SW;
            OP_SB, OP_SH:                                       op_class = CLS_PSTORE;
            default:                                            op_class = CLS_NONMEM;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_wait_timer.sv
// Saturating count of consecutive wait-request cycles; flags the edge on which
// the WAIT_TIMEOUT-th consecutive waiting cycle completes.
module mips_cpu_wait_timer #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    input  logic waiting,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clk_enable) begin
            if (!waiting) begin
                count <= '0;
            end else if (count != LIMIT) begin
                count <= count + 1'b1;
            end
        end
    end

    // Fires during the cycle whose edge brings the count up to WAIT_TIMEOUT.
    assign expired = clk_enable && waiting && (count >= LAST);

endmodule

// File: rtl/mips_cpu_mem_sequencer.sv
// Multi-cycle memory controller beside the main decoder: stalls the PC during
// bus waits, runs SB/SH as read-merge-write, and detects halt and bus timeout.
import mips_cpu_seq_pkg::*;

module mips_cpu_mem_sequencer #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_enable,
    input  logic [5:0] opcode,
    input  logic       instr_waitrequest,
    input  logic       data_waitrequest,
    input  logic       active,
    output logic       stall,
    output logic       storeloop,
    output logic       data_read,
    output logic       data_write,
    output logic       halted,
    output logic       bus_error
);

    state_t    state;
    state_t    state_next;
    op_class_t op_cls;
    logic      waiting;
    logic      expired;

    assign op_cls = op_class(opcode);

    mips_cpu_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clk_enable(clk_enable),
        .waiting   (waiting),
        .expired   (expired)
    );

    // Mealy outputs; the safe default (stalled, bus idle) also covers reset and freeze.
    always_comb begin
        stall      = 1'b1;
        storeloop  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        waiting    = 1'b0;
        halted     = reset && (state == HALTED);
        bus_error  = reset && (state == ERROR);
        if (reset && clk_enable) begin
            case (state)
                RUN: begin
                    if (active && instr_waitrequest) begin
                        waiting = 1'b1;
                    end else if (active) begin
                        case (op_cls)
                            CLS_LOAD: begin
                                data_read = 1'b1;
                                stall     = data_waitrequest;
                                waiting   = data_waitrequest;
                            end
                            CLS_SW: begin
                                data_write = 1'b1;
                                stall      = data_waitrequest;
                                waiting    = data_waitrequest;
                            end
                            CLS_PSTORE: begin
                                data_read = 1'b1;
                                waiting   = data_waitrequest;
                            end
                            default: stall = 1'b0;
                        endcase
                    end
                end
                RMW_CAPTURE: storeloop = 1'b1;
                RMW_WRITE: begin
                    storeloop  = 1'b1;
                    data_write = 1'b1;
                    stall      = data_waitrequest;
                    waiting    = data_waitrequest;
                end
                default: ;
            endcase
        end
    end

    // A timeout overrides every other transition; HALTED and ERROR only leave via reset.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (!active) begin
                    state_next = HALTED;
                end else if (!instr_waitrequest && op_cls == CLS_PSTORE && !data_waitrequest) begin
                    state_next = RMW_CAPTURE;
                end
            end
            RMW_CAPTURE: state_next = RMW_WRITE;
            RMW_WRITE: begin
                if (!data_waitrequest) begin
                    state_next = RUN;
                end
            end
            default: ;
        endcase
        if (expired) begin
            state_next = ERROR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else if (clk_enable) begin
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the sequencing rules.
module tb_mips_cpu_mem_sequencer;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_enable;
    logic [5:0] opcode;
    logic       instr_waitrequest;
    logic       data_waitrequest;
    logic       active;
    logic       stall;
    logic       storeloop;
    logic       data_read;
    logic       data_write;
    logic       halted;
    logic       bus_error;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: pending partial-store step (0 none, 1 capture, 2 write), sticky flags, wait run length.
    int m_step = 0;
    bit m_halt = 0;
    bit m_err  = 0;
    int m_wait = 0;

    logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h20, 6'h26, 6'h27, 6'h28, 6'h29, 6'h2B, 6'h2A, 6'h1F};

    mips_cpu_mem_sequencer #(
        .WAIT_TIMEOUT(TIMEOUT),
        .CNT_W       (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_enable       (clk_enable),
        .opcode           (opcode),
        .instr_waitrequest(instr_waitrequest),
        .data_waitrequest (data_waitrequest),
        .active           (active),
        .stall            (stall),
        .storeloop        (storeloop),
        .data_read        (data_read),
        .data_write       (data_write),
        .halted           (halted),
        .bus_error        (bus_error)
    );

    always #5 clk = ~clk;

    function automatic bit is_load(input logic [5:0] op);
        return (op >= 6'h20) && (op <= 6'h26);
    endfunction

    function automatic bit is_pstore(input logic [5:0] op);
        return (op == 6'h28) || (op == 6'h29);
    endfunction

    // Expected {stall, storeloop, data_read, data_write, halted, bus_error}.
    function automatic logic [5:0] model_outputs();
        if (!reset)                         return 6'b100000;
        if (m_err)                          return 6'b100001;
        if (m_halt)                         return 6'b100010;
        if (!clk_enable)                    return 6'b100000;
        if (m_step == 1)                    return 6'b110000;
        if (m_step == 2)                    return {data_waitrequest, 5'b10100};
        if (!active || instr_waitrequest)   return 6'b100000;
        if (is_load(opcode))                return {data_waitrequest, 5'b01000};
        if (opcode == 6'h2B)                return {data_waitrequest, 5'b00100};
        if (is_pstore(opcode))              return 6'b101000;
        return 6'b000000;
    endfunction

    function automatic bit model_waiting();
        if (!clk_enable || m_err || m_halt) return 0;
        if (m_step == 1)                    return 0;
        if (m_step == 2)                    return data_waitrequest;
        if (!active)                        return 0;
        if (instr_waitrequest)              return 1;
        if (is_load(opcode) || is_pstore(opcode) || opcode == 6'h2B) return data_waitrequest;
        return 0;
    endfunction

    task automatic model_update();
        if (!reset) begin
            m_step = 0;
            m_halt = 0;
            m_err  = 0;
            m_wait = 0;
            return;
        end
        if (!clk_enable || m_err || m_halt) return;
        if (model_waiting()) m_wait++;
        else m_wait = 0;
        if (m_wait >= TIMEOUT) begin
            m_err  = 1;
            m_step = 0;
            return;
        end
        case (m_step)
            1: m_step = 2;
            2: if (!data_waitrequest) m_step = 0;
            default: begin
                if (!active) m_halt = 1;
                else if (!instr_waitrequest && is_pstore(opcode) && !data_waitrequest) m_step = 1;
            end
        endcase
    endtask

    task automatic apply_stimulus(input bit rst, input bit en, input logic [5:0] op,
                                  input bit iw, input bit dw, input bit act);
        reset             = rst;
        clk_enable        = en;
        opcode            = op;
        instr_waitrequest = iw;
        data_waitrequest  = dw;
        active            = act;
    endtask

    // Sample on the falling edge, compare, then advance the model across the rising edge.
    task automatic check_output(input string tag, input bit has_exp, input logic [5:0] exp);
        logic [5:0] obs;
        logic [5:0] mdl;
        @(negedge clk);
        obs = {stall, storeloop, data_read, data_write, halted, bus_error};
        mdl = model_outputs();
        tests_run++;
        assert (obs === mdl) else begin
            tests_failed++;
            $error("[TB] FAIL %s model: observed %b expected %b", tag, obs, mdl);
        end
        if (has_exp) begin
            tests_run++;
            assert (obs === exp) else begin
                tests_failed++;
                $error("[TB] FAIL %s directed: observed %b expected %b", tag, obs, exp);
            end
        end
        tests_run++;
        assert ((data_read && data_write) === 1'b0) else begin
            tests_failed++;
            $error("[TB] FAIL %s exclusive: observed rd=%b wr=%b expected not both", tag, data_read, data_write);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        apply_stimulus(0, 1, 6'h00, 0, 0, 1);
        check_output("reset_0", 1, 6'b100000);
        check_output("reset_1", 1, 6'b100000);

        apply_stimulus(1, 1, 6'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) check_output("addu", 1, 6'b000000);

        apply_stimulus(1, 1, 6'h23, 0, 1, 1);
        for (int i = 0; i < 3; i++) check_output("lw_wait", 1, 6'b101000);
        apply_stimulus(1, 1, 6'h23, 0, 0, 1);
        check_output("lw_done", 1, 6'b001000);
        apply_stimulus(1, 1, 6'h23, 0, 1, 1);
        for (int i = 0; i < 3; i++) check_output("lw_wait_again", 1, 6'b101000);
        apply_stimulus(1, 1, 6'h00, 0, 0, 1);
        check_output("lw_after", 1, 6'b000000);

        apply_stimulus(1, 1, 6'h28, 0, 0, 1);
        check_output("sb_read", 1, 6'b101000);
        check_output("sb_capture", 1, 6'b110000);
        check_output("sb_write", 1, 6'b010100);
        apply_stimulus(1, 1, 6'h00, 0, 0, 1);
        check_output("sb_run", 1, 6'b000000);

        apply_stimulus(1, 1, 6'h29, 0, 0, 1);
        check_output("sh_read", 1, 6'b101000);
        apply_stimulus(1, 1, 6'h29, 0, 1, 1);
        check_output("sh_capture", 1, 6'b110000);
        check_output("sh_write_wait", 1, 6'b110100);
        apply_stimulus(1, 1, 6'h29, 0, 0, 1);
        check_output("sh_write", 1, 6'b010100);

        apply_stimulus(1, 1, 6'h29, 0, 0, 1);
        check_output("sh_rst_read", 1, 6'b101000);
        apply_stimulus(0, 1, 6'h00, 0, 0, 1);
        check_output("sh_rst_capture", 1, 6'b100000);
        apply_stimulus(1, 1, 6'h00, 0, 0, 1);
        check_output("sh_rst_release", 1, 6'b000000);
        check_output("sh_rst_release2", 1, 6'b000000);

        apply_stimulus(1, 1, 6'h2B, 0, 1, 1);
        for (int i = 0; i < TIMEOUT; i++) check_output("sw_wait", 1, 6'b100100);
        check_output("sw_timeout", 1, 6'b100001);
        apply_stimulus(1, 1, 6'h00, 0, 0, 1);
        for (int i = 0; i < 3; i++) check_output("error_sticky", 1, 6'b100001);
        apply_stimulus(0, 1, 6'h00, 0, 0, 1);
        check_output("error_reset", 1, 6'b100000);

        apply_stimulus(1, 1, 6'h00, 1, 0, 1);
        check_output("ifetch_wait", 1, 6'b100000);
        apply_stimulus(1, 1, 6'h00, 1, 0, 0);
        check_output("active_low", 1, 6'b100000);
        check_output("halted", 1, 6'b100010);
        apply_stimulus(1, 1, 6'h00, 0, 0, 1);
        for (int i = 0; i < 2; i++) check_output("halted_sticky", 1, 6'b100010);
        apply_stimulus(1, 0, 6'h00, 0, 0, 1);
        check_output("halted_frozen", 1, 6'b100010);
        apply_stimulus(0, 1, 6'h00, 0, 0, 1);
        check_output("halt_reset", 1, 6'b100000);

        apply_stimulus(1, 0, 6'h23, 0, 1, 1);
        for (int i = 0; i < 6; i++) check_output("frozen", 1, 6'b100000);
        apply_stimulus(1, 1, 6'h23, 0, 1, 1);
        check_output("unfrozen_lw", 1, 6'b101000);
        apply_stimulus(1, 1, 6'h00, 0, 0, 1);
        check_output("unfrozen_addu", 1, 6'b000000);

        for (int i = 0; i < 3000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 99) != 0) && !((m_err || m_halt) && ($urandom_range(0, 7) == 0));
            apply_stimulus(rst, $urandom_range(0, 7) != 0, ops[$urandom_range(0, 9)],
                           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 63) != 0);
            check_output("random", 0, 6'b000000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
